// File: rtl/qspi_flash_reader_pkg.sv
// Shared QSPI definitions: register map, CCR layout, opcodes and data-mode encodings,
// plus the reader FSM state type.
package qspi_flash_reader_pkg;

  typedef enum logic [5:0] {
    REG_CCR = 6'd0,
    REG_ADR = 6'd4,
    REG_DR  = 6'd8,
    REG_STA = 6'd40
  } reg_off_e;

  typedef enum logic [7:0] {
    OP_PP   = 8'h02,
    OP_READ = 8'h03,
    OP_QPP  = 8'h32,
    OP_DOR  = 8'h3B,
    OP_QOR  = 8'h6B
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_X1 = 2'b01,
    MODE_X2 = 2'b10,
    MODE_X4 = 2'b11
  } data_mode_e;

  // Field order of this struct is the CCR bit layout, MSB first.
  typedef struct packed {
    logic       start;
    logic [5:0] prescaler;
    logic [3:0] rsvd;
    logic [4:0] size;
    logic [4:0] dummy;
    logic       write;
    logic [1:0] mode;
    logic [7:0] cmd;
  } ccr_t;

  localparam logic [31:0] STA_IDLE  = 32'd1;
  localparam logic [4:0]  SIZE_WORD = 5'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADR,
    ST_WR_CCR,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_RD_DR,
    ST_RESP
  } state_e;

  function automatic logic [31:0] ccr_read_word(input logic [5:0] prescaler,
                                                input logic [4:0] dummy,
                                                input logic [1:0] mode,
                                                input logic [7:0] cmd);
    ccr_t c;
    c.start     = 1'b1;
    c.prescaler = prescaler;
    c.rsvd      = 4'b0;
    c.size      = SIZE_WORD;
    c.dummy     = dummy;
    c.write     = 1'b0;
    c.mode      = mode;
    c.cmd       = cmd;
    return c;
  endfunction

endpackage

// File: rtl/qspi_flash_reader_if.sv
// Request/response handshake and QSPI-master register bus seen by the flash reader.
// slave = reader side, master = environment (requester + register file) side.
interface qspi_flash_reader_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [23:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        qspi_write_o;
  logic [3:0]  qspi_be_o;
  logic [5:0]  qspi_addr_o;
  logic [31:0] qspi_wdata_o;
  logic [31:0] qspi_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, qspi_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
           qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, qspi_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
           qspi_write_o, qspi_be_o, qspi_addr_o, qspi_wdata_o
  );
endinterface

// File: rtl/qspi_flash_reader.sv
// Sequences one flash word read on the QSPI master register bus:
// program ADR, program+start CCR, poll STA, fetch DR, hand the word back.
module qspi_flash_reader
  import qspi_flash_reader_pkg::*;
#(
  parameter logic [7:0]  RD_CMD    = OP_QOR,
  parameter logic [1:0]  DATA_MODE = MODE_X4,
  parameter logic [4:0]  DUMMY     = 5'd4,
  parameter logic [5:0]  PRESCALER = 6'd1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input logic                clk_i,
  input logic                rst_ni,
  qspi_flash_reader_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      CCR_RD   = ccr_read_word(PRESCALER, DUMMY, DATA_MODE, RD_CMD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  logic             sta_idle;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q,  rsp_data_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        busy_q,      busy_d;
  logic        write_q,     write_d;
  logic [3:0]  be_q,        be_d;
  logic [5:0]  addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;

  assign sta_idle = (bus.qspi_rdata_i == STA_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= '0;
      addr_q      <= REG_STA;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      write_q     <= write_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Read data lags the register address by one cycle, so STA is first trusted on the
  // second WAIT_START cycle and DR on the second RD_DR cycle (cnt_q != 0).
  always_comb begin
    state_d   = state_q;
    timed_out = 1'b0;
    unique case (state_q)
      ST_IDLE:       if (bus.req_valid_i && req_ready_q) state_d = ST_WR_ADR;
      ST_WR_ADR:     state_d = ST_WR_CCR;
      ST_WR_CCR:     state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (cnt_q != '0 && !sta_idle) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          timed_out = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (sta_idle) begin
          state_d = ST_RD_DR;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          timed_out = 1'b1;
        end
      end
      ST_RD_DR:      if (cnt_q != '0) state_d = ST_RESP;
      ST_RESP:       if (bus.rsp_ready_i) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    cnt_d = '0;
    if (state_d == state_q && state_q inside {ST_WAIT_START, ST_WAIT_DONE, ST_RD_DR})
      cnt_d = cnt_q + 1'b1;
  end

  // Registered outputs are computed from the state being entered.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    write_d     = (state_d == ST_WR_ADR) || (state_d == ST_WR_CCR);
    be_d        = write_d ? 4'b1111 : 4'b0000;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_d)
      ST_WR_ADR: begin
        addr_d  = REG_ADR;
        wdata_d = {8'h00, bus.req_addr_i};
      end
      ST_WR_CCR: begin
        addr_d  = REG_CCR;
        wdata_d = CCR_RD;
      end
      ST_RD_DR: begin
        addr_d  = REG_DR;
        wdata_d = '0;
      end
      default: begin
        addr_d  = REG_STA;
        wdata_d = '0;
      end
    endcase

    if (timed_out) begin
      rsp_err_d  = 1'b1;
      rsp_data_d = '0;
    end else if (state_q == ST_RD_DR && state_d == ST_RESP) begin
      rsp_data_d = bus.qspi_rdata_i;
    end else if (state_q == ST_RESP && state_d == ST_IDLE) begin
      rsp_err_d = 1'b0;
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.busy_o       = busy_q;
  assign bus.qspi_write_o = write_q;
  assign bus.qspi_be_o    = be_q;
  assign bus.qspi_addr_o  = addr_q;
  assign bus.qspi_wdata_o = wdata_q;

endmodule
